// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiplier: widths, FSM encoding and the
// legality rule for the per-cycle radix.
package mul_pkg;

  localparam int MUL_W  = 32;
  localparam int PROD_W = 64;
  localparam int CNT_W  = 5;

  typedef logic [1:0] mul_state_t;

  localparam mul_state_t ST_IDLE = 2'd0;
  localparam mul_state_t ST_CALC = 2'd1;
  localparam mul_state_t ST_SIGN = 2'd2;
  localparam mul_state_t ST_DONE = 2'd3;

  function automatic bit bpc_is_legal(int bpc);
    return (bpc == 1) || (bpc == 2) || (bpc == 4);
  endfunction

endpackage

// File: rtl/mul_step.sv
// One shift-add step: folds mag_a times a small multiplier slice, weighted by the
// slice position, into the running 64-bit accumulator.
module mul_step
  import mul_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic [PROD_W-1:0]         acc,
  input  logic [MUL_W-1:0]          mag_a,
  input  logic [BITS_PER_CYCLE-1:0] slice,
  input  logic [CNT_W-1:0]          cnt,
  output logic [PROD_W-1:0]         acc_nxt
);

  logic [5:0]        shamt;
  logic [PROD_W-1:0] partial;

  assign shamt   = 6'(int'(cnt) * BITS_PER_CYCLE);
  assign partial = PROD_W'(mag_a) * PROD_W'(slice);
  assign acc_nxt = acc + (partial << shamt);

endmodule

// File: rtl/iter_mul_unit.sv
// Iterative 32x32->64 multiplier for the execute stage. Works on magnitudes, fixes
// the sign in a final cycle, and keeps the last product for a repeated request.
module iter_mul_unit
  import mul_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              is_unsign,
  input  logic [MUL_W-1:0]  a,
  input  logic [MUL_W-1:0]  b,
  output logic [PROD_W-1:0] result,
  output logic              done
);

  localparam int MUL_CYCLES = MUL_W / BITS_PER_CYCLE;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_CYCLES - 1);

  if (!bpc_is_legal(BITS_PER_CYCLE)) begin : g_bad_bpc
    $error("iter_mul_unit: BITS_PER_CYCLE must be 1, 2 or 4");
  end

  mul_state_t        state;
  logic [MUL_W-1:0]  a_l, b_l, mag_a, mag_b;
  logic              s_l, neg;
  logic [PROD_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0]  cnt;

  logic                      match, load;
  logic [MUL_W-1:0]          abs_a, abs_b;
  logic [BITS_PER_CYCLE-1:0] slice;
  logic [CNT_W-1:0]          bit_pos;

  assign match = (a == a_l) && (b == b_l) && (is_unsign == s_l);
  assign done  = (state == ST_DONE) && enable && match;

  // A fresh request from IDLE, or a different request replacing the current one
  // anywhere else, restarts the computation on the same edge.
  assign load = enable && ((state == ST_IDLE) || !match);

  assign abs_a = (!is_unsign && a[MUL_W-1]) ? -a : a;
  assign abs_b = (!is_unsign && b[MUL_W-1]) ? -b : b;

  assign bit_pos = CNT_W'(int'(cnt) * BITS_PER_CYCLE);
  assign slice   = BITS_PER_CYCLE'(mag_b >> bit_pos);

  mul_step #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_step (
    .acc     (acc),
    .mag_a   (mag_a),
    .slice   (slice),
    .cnt     (cnt),
    .acc_nxt (acc_nxt)
  );

  // NOTE: every register here is written with <= so all of them sample the
  // pre-edge values of each other; blocking assignments would chain them.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      result <= '0;
      a_l    <= '0;
      b_l    <= '0;
      s_l    <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      neg    <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
    end else if (load) begin
      a_l   <= a;
      b_l   <= b;
      s_l   <= is_unsign;
      mag_a <= abs_a;
      mag_b <= abs_b;
      neg   <= !is_unsign && (a[MUL_W-1] ^ b[MUL_W-1]);
      acc   <= '0;
      cnt   <= '0;
      state <= ST_CALC;
    end else begin
      // Past the load check, a non-IDLE state with enable high always has a match.
      case (state)
        ST_CALC: begin
          if (!enable) begin
            state <= ST_IDLE;
          end else begin
            acc <= acc_nxt;
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_CNT) state <= ST_SIGN;
          end
        end
        ST_SIGN: begin
          if (!enable) begin
            state <= ST_IDLE;
          end else begin
            result <= neg ? -acc : acc;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!enable) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_mul_unit.sv
// Directed bench for iter_mul_unit: a table of hand-computed products plus
// hand-written hold, abort, flush and reset sequences.
module tb_iter_mul_unit;

  localparam int LAT   = 18;
  localparam int BOUND = 40;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        is_unsign;
  logic [31:0] a, b;
  logic [63:0] result;
  logic        done;

  int checks   = 0;
  int failures = 0;

  iter_mul_unit #(.BITS_PER_CYCLE(2)) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .is_unsign (is_unsign),
    .a         (a),
    .b         (b),
    .result    (result),
    .done      (done)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        u;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Counts negedges until done is seen, giving up after BOUND cycles.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < BOUND) begin
      @(negedge sys_clk);
      cyc++;
      if (done === 1'b1) break;
    end
  endtask

  task automatic start(input logic [31:0] av, input logic [31:0] bv, input logic u);
    @(negedge sys_clk);
    a = av; b = bv; is_unsign = u; enable = 1'b1;
  endtask

  task automatic drop_enable(input string name);
    @(negedge sys_clk);
    enable = 1'b0;
    #1 check({name, "_done_drop"}, 64'(done), 64'd0);
  endtask

  initial begin
    int cyc;

    vecs[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001};
    vecs[1] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000};
    vecs[2] = '{32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 64'hFFFF_FFFF_FFFF_FFF1};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'h0000_0000_0000_0001};
    vecs[4] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 64'hC000_0000_8000_0000};
    vecs[5] = '{32'h8000_0000, 32'h0000_0002, 1'b1, 64'h0000_0001_0000_0000};
    vecs[6] = '{32'h0000_0000, 32'hFFFF_FFFB, 1'b0, 64'h0000_0000_0000_0000};
    vecs[7] = '{32'h0001_2345, 32'h0000_1000, 1'b1, 64'h0000_0000_1234_5000};

    rst_n = 1'b0; enable = 1'b0; is_unsign = 1'b1; a = '0; b = '0;
    #12;
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", result, 64'd0);
    @(negedge sys_clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      start(vecs[i].a, vecs[i].b, vecs[i].u);
      wait_done(cyc);
      check($sformatf("vec%0d_latency", i), 64'(cyc), 64'(LAT));
      check($sformatf("vec%0d_result", i), result, vecs[i].exp);
      drop_enable($sformatf("vec%0d", i));
    end

    // Cached result held across a stall, then an operand change mid-hold.
    start(32'd7, 32'd6, 1'b1);
    wait_done(cyc);
    check("hold_latency", 64'(cyc), 64'(LAT));
    check("hold_result", result, 64'd42);
    for (int k = 0; k < 5; k++) begin
      @(negedge sys_clk);
      check($sformatf("hold%0d_done", k), 64'(done), 64'd1);
      check($sformatf("hold%0d_result", k), result, 64'd42);
    end
    @(negedge sys_clk);
    b = 32'd9;
    #1 check("change_done_drop", 64'(done), 64'd0);
    wait_done(cyc);
    check("change_latency", 64'(cyc), 64'(LAT));
    check("change_result", result, 64'd63);
    drop_enable("change");

    // Abort in CALC, then the same request again needs the full latency.
    start(32'd3, 32'd4, 1'b1);
    repeat (6) @(negedge sys_clk);
    enable = 1'b0;
    #1 check("abort_done", 64'(done), 64'd0);
    @(negedge sys_clk);
    enable = 1'b1;
    #1 check("abort_restart_done", 64'(done), 64'd0);
    wait_done(cyc);
    check("abort_latency", 64'(cyc), 64'(LAT));
    check("abort_result", result, 64'd12);
    drop_enable("abort");

    // Flush: operand a replaced mid-CALC restarts the computation.
    start(32'd2, 32'd10, 1'b1);
    repeat (9) @(negedge sys_clk);
    a = 32'd10;
    #1 check("flush_done_drop", 64'(done), 64'd0);
    wait_done(cyc);
    check("flush_latency", 64'(cyc), 64'(LAT));
    check("flush_result", result, 64'd100);
    drop_enable("flush");

    // Asynchronous reset in CALC clears result and done immediately.
    start(32'd5, 32'd5, 1'b1);
    repeat (6) @(negedge sys_clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_done", 64'(done), 64'd0);
    check("midreset_result", result, 64'd0);
    a = 32'd1; b = 32'd1;
    @(negedge sys_clk);
    rst_n = 1'b1;
    wait_done(cyc);
    check("postreset_latency", 64'(cyc), 64'(LAT));
    check("postreset_result", result, 64'd1);
    drop_enable("postreset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iter_mul_unit.md
Name: iter_mul_unit

Overview:
- Iterative 32x32→64 multiplier that serves the execute stage's multiply request: enable, is_unsign, a, b in; result, done out.
- Execute derives its stall from enable && !done, so this block controls how long a mul/muh instruction holds the EX stage.
- Signed multiply works on operand magnitudes; the sign is corrected in a final cycle.
- Completed results are kept, so a re-presented identical request completes with no recompute.

Parameters:
- BITS_PER_CYCLE, 2: multiplier bits retired per CALC cycle. Legal values are 1, 2, 4.
- MUL_CYCLES, 32/BITS_PER_CYCLE: derived, not overridable.

Ports:
- sys_clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  request. Held high with stable operands for as long as execute is stalled.
- is_unsign  in  1  1 = unsigned multiply, 0 = signed (two's complement)
- a  in  32  multiplicand (rs)
- b  in  32  multiplier (rt)
- result  out  64  full product. Valid only while done=1.
- done  out  1  product for the current {a,b,is_unsign} is available

Behaviour:
- Reset (async, rst_n low): state=IDLE, result=0, done=0, all latches/accumulators=0. Reset mid-operation discards the operation.
- Internal latches: a_l, b_l, s_l (the presented operands and sign mode); mag_a, mag_b (32-bit unsigned magnitudes); neg (product sign); acc (64-bit accumulator); cnt.
- match = (a==a_l) && (b==b_l) && (is_unsign==s_l).
- done = (state==DONE) && enable && match. This is combinational; no extra cycle.
- States: IDLE, CALC, SIGN, DONE.
- IDLE:
  - if enable: latch a_l, b_l, s_l.
  - mag_a = (signed && a[31]) ? -a : a; same rule for mag_b.
  - neg = signed && (a[31]^b[31]).
  - acc=0, cnt=0 → CALC.
  - -2^31 has magnitude 0x80000000, which is legal unsigned.
- CALC:
  - each cycle adds mag_a * (next BITS_PER_CYCLE bits of mag_b, LSB first), shifted by cnt*BITS_PER_CYCLE, into acc.
  - cnt increments. After MUL_CYCLES cycles → SIGN.
- SIGN: result = neg ? -acc : acc (64-bit two's complement) → DONE.
- DONE: stays while enable && match, with done=1.
  - !enable → IDLE.
  - enable && !match → behaves as IDLE with a new request: relatch and go to CALC in the same edge.
- Abort/restart in CALC or SIGN:
  - !enable → IDLE; result keeps its old value.
  - enable && !match (flush replaced the instruction) → relatch and restart CALC at cnt=0.
- Latency: enable rises in IDLE at edge 0 → done=1 after edge MUL_CYCLES+2 (18 cycles at default).
- Back-to-back multiplies:
  - a new request with different operands after done → full latency.
  - an identical request (same a, b, is_unsign) → done stays high and the cached result is returned. This is correct by construction.
- Stall from another source with a mul held in EX: remains in DONE, done=1, no recompute.
- Low/high selection of result is execute's job. This block always outputs all 64 bits.
- No X propagation: result updates only in SIGN.

Decomposition:
- Shared package mul_pkg holds:
  - state enum (IDLE, CALC, SIGN, DONE), 2-bit encoding
  - MUL_W=32 and PROD_W=64
  - legal BITS_PER_CYCLE values, checked by a static assertion in the unit
- Sub-module mul_step: combinational. Takes acc, mag_a, a BITS_PER_CYCLE-bit multiplier slice and cnt; returns the next acc. It is instantiated once in CALC.
- Sign pre/post processing stays inline.

Test Plan:
- Unsigned: is_unsign=1, a=b=0xFFFFFFFF, enable held → done after exactly 18 cycles, result=0xFFFFFFFE_00000001. done deasserts the cycle enable falls.
- Signed corner: is_unsign=0, a=b=0x80000000 → result=0x40000000_00000000. Also a=0xFFFFFFFD (-3), b=5 → result=0xFFFFFFFF_FFFFFFF1. Also a=b=0xFFFFFFFF → result=1.
- Cache/hold: after done with a=7, b=6 (result=42), keep enable high 5 more cycles → done stays 1, result stays 42, state stays DONE. Then change b to 9 while enable high → done=0 the same cycle, result=63 after 18 cycles.
- Abort: start a=3, b=4, drop enable at CALC cycle 5 → IDLE, done=0. Re-raise enable with a=3, b=4 → full 18-cycle latency, result=12.
- Flush restart: in CALC cycle 8, change a from 2 to 10 (b=10, enable high) → restart, done 18 cycles after the change, result=100, never 20.
- Reset mid-op: assert rst_n=0 asynchronously in CALC → result=0, done=0 immediately. After release with enable high and a=b=1 → result=1 after 18 cycles.
